// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundles the signals between the multi-cycle MIPS controller and its
//   datapath.
//
//   Controller inputs (driven by the datapath):
//     op[5:0]        IR[31:26]
//     func[5:0]      IR[5:0]
//     zero           ALU result == 0
//     mem_ready      memory access completes this cycle
//
//   Controller outputs (driven by the controller):
//     PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst[1:0], MemtoReg[1:0],
//     ALUSrcA, ALUSrcB[1:0], ALUControl[2:0], sign, PCSource[1:0],
//     instr_done, illegal, instr_cnt[31:0]
//
//   Modports:
//     master  the controller, which drives the control bus
//     slave   the datapath, which consumes the controls
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        zero;
  logic        mem_ready;

  logic        PCWrite;
  logic        IorD;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic        sign;
  logic [1:0]  PCSource;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instr_cnt;

  modport master (
    input  op, func, zero, mem_ready,
    output PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUControl, sign, PCSource,
           instr_done, illegal, instr_cnt
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUControl, sign, PCSource,
           instr_done, illegal, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencing controller for the MIPS core. Decodes op/func in
//   DECODE and walks a Moore FSM that drives the PC, IR, memory, register
//   file and ALU controls over a shared memory port and a single ALU.
//   Supports memory wait states, counts retired instructions (including
//   illegal ones) and flags unsupported encodings.
//
//   Parameters:
//     USE_MEM_READY  1: FETCH/MEMRD/MEMWR wait for mem_ready
//                    0: mem_ready ignored (treated as 1)
//     CNT_INIT       value loaded into instr_cnt by reset (normally 0)
//
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-high; FSM -> FETCH, counter cleared
//     bus    multicycle_ctrl_if.master (see interface for signal list)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int          USE_MEM_READY = 1,
  parameter logic [31:0] CNT_INIT      = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_IMM_EX,
    S_IMM_WB,
    S_BEQ,
    S_J,
    S_JAL,
    S_JR
  } state_t;

  // Instruction class captured in DECODE; later states only look at this.
  typedef enum logic [3:0] {
    K_ADDU,   // addu and nop
    K_SUBU,
    K_JR,
    K_ORI,
    K_LUI,
    K_LW,
    K_LH,
    K_SW,
    K_BEQ,
    K_J,
    K_JAL,
    K_ILL
  } kind_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  state_t      r_state;
  kind_t       r_kind;
  logic [31:0] r_cnt;

  // Registered Moore decodes
  logic        r_iord;
  logic        r_alusrca;
  logic [1:0]  r_alusrcb;
  logic [2:0]  r_aluctl;
  logic        r_sign;
  logic [1:0]  r_pcsrc;
  logic [1:0]  r_regdst;
  logic [1:0]  r_memtoreg;
  logic        r_regwrite;
  logic        r_memwrite;
  logic        r_pcwrite;   // unconditional PC load (j/jal/jr)
  logic        r_done;      // unconditional retire (write-back / jump / beq)

  state_t      w_next;
  kind_t       w_dec_kind;
  kind_t       w_kind_nxt;
  logic        w_rdy;
  logic        w_run;
  logic        w_dec_ill;
  logic        w_in_fetch;
  logic        w_in_decode;
  logic        w_in_memwr;
  logic        w_in_beq;
  logic        w_done;

  assign w_rdy       = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;
  assign w_run       = ~reset;
  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_in_decode = (r_state == S_DECODE);
  assign w_in_memwr  = (r_state == S_MEMWR);
  assign w_in_beq    = (r_state == S_BEQ);

  // -------------------------------------------------------------------------
  // Instruction decode (only consumed while in DECODE)
  // -------------------------------------------------------------------------
  always_comb begin
    w_dec_kind = K_ILL;
    case (bus.op)
      6'b000000: begin
        case (bus.func)
          6'b100001: w_dec_kind = K_ADDU;
          6'b100011: w_dec_kind = K_SUBU;
          6'b001000: w_dec_kind = K_JR;
          6'b000000: w_dec_kind = K_ADDU;
          default:   w_dec_kind = K_ILL;
        endcase
      end
      6'b001101: w_dec_kind = K_ORI;
      6'b001111: w_dec_kind = K_LUI;
      6'b100011: w_dec_kind = K_LW;
      6'b100001: w_dec_kind = K_LH;
      6'b101011: w_dec_kind = K_SW;
      6'b000100: w_dec_kind = K_BEQ;
      6'b000010: w_dec_kind = K_J;
      6'b000011: w_dec_kind = K_JAL;
      default:   w_dec_kind = K_ILL;
    endcase
  end

  assign w_dec_ill  = (w_dec_kind == K_ILL);
  assign w_kind_nxt = w_in_decode ? w_dec_kind : r_kind;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_dec_kind)
          K_ADDU, K_SUBU:     w_next = S_RTYPE_EX;
          K_ORI, K_LUI:       w_next = S_IMM_EX;
          K_LW, K_LH, K_SW:   w_next = S_MEMADR;
          K_BEQ:              w_next = S_BEQ;
          K_J:                w_next = S_J;
          K_JAL:              w_next = S_JAL;
          K_JR:               w_next = S_JR;
          default:            w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (r_kind == K_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:    w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: w_next = S_RTYPE_WB;
      S_IMM_EX:   w_next = S_IMM_WB;
      S_MEMWB,
      S_RTYPE_WB,
      S_IMM_WB,
      S_BEQ,
      S_J,
      S_JAL,
      S_JR:       w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, instruction class, retire counter and registered Moore outputs.
  // Outputs are decoded from the state being entered so that they are
  // registered yet still line up with the state they belong to.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_kind     <= K_ADDU;
      r_cnt      <= CNT_INIT;
      r_iord     <= 1'b0;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 2'b01;
      r_aluctl   <= ALU_ADD;
      r_sign     <= 1'b0;
      r_pcsrc    <= 2'b00;
      r_regdst   <= 2'b00;
      r_memtoreg <= 2'b00;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_in_decode) begin
        r_kind <= w_dec_kind;
      end
      if (w_done) begin
        r_cnt <= r_cnt + 32'd1;
      end

      r_iord     <= 1'b0;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 2'b00;
      r_aluctl   <= ALU_ADD;
      r_sign     <= 1'b0;
      r_pcsrc    <= 2'b00;
      r_regdst   <= 2'b00;
      r_memtoreg <= 2'b00;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_done     <= 1'b0;

      case (w_next)
        S_FETCH: begin
          r_alusrcb <= 2'b01;
        end
        S_DECODE: begin
          // Branch target PC + (imm << 2) computed speculatively into ALUOut.
          r_alusrcb <= 2'b11;
          r_sign    <= 1'b1;
        end
        S_MEMADR: begin
          r_alusrca <= 1'b1;
          r_alusrcb <= 2'b10;
          r_sign    <= 1'b1;
        end
        S_MEMRD: begin
          r_iord <= 1'b1;
        end
        S_MEMWB: begin
          r_regwrite <= 1'b1;
          r_memtoreg <= (w_kind_nxt == K_LH) ? 2'b10 : 2'b01;
          r_done     <= 1'b1;
        end
        S_MEMWR: begin
          r_iord     <= 1'b1;
          r_memwrite <= 1'b1;
        end
        S_RTYPE_EX: begin
          r_alusrca <= 1'b1;
          r_aluctl  <= (w_kind_nxt == K_SUBU) ? ALU_SUB : ALU_ADD;
        end
        S_RTYPE_WB: begin
          r_regdst   <= 2'b01;
          r_regwrite <= 1'b1;
          r_done     <= 1'b1;
        end
        S_IMM_EX: begin
          r_alusrca <= 1'b1;
          r_alusrcb <= 2'b10;
          r_aluctl  <= (w_kind_nxt == K_LUI) ? ALU_LUI : ALU_OR;
        end
        S_IMM_WB: begin
          r_regwrite <= 1'b1;
          r_done     <= 1'b1;
        end
        S_BEQ: begin
          r_alusrca <= 1'b1;
          r_aluctl  <= ALU_SUB;
          r_pcsrc   <= 2'b01;
          r_done    <= 1'b1;
        end
        S_J: begin
          r_pcsrc   <= 2'b10;
          r_pcwrite <= 1'b1;
          r_done    <= 1'b1;
        end
        S_JAL: begin
          // PC already holds PC+4 here, which is the link value.
          r_pcsrc    <= 2'b10;
          r_pcwrite  <= 1'b1;
          r_regdst   <= 2'b10;
          r_memtoreg <= 2'b11;
          r_regwrite <= 1'b1;
          r_done     <= 1'b1;
        end
        S_JR: begin
          r_pcsrc   <= 2'b11;
          r_pcwrite <= 1'b1;
          r_done    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Strobes that also depend on mem_ready/zero/op in the current cycle, and
  // forcing of all write strobes low while reset is held.
  // -------------------------------------------------------------------------
  assign w_done = w_run & (r_done
                         | (w_in_memwr  & w_rdy)
                         | (w_in_decode & w_dec_ill));

  assign bus.PCWrite    = w_run & (r_pcwrite
                                 | (w_in_fetch & w_rdy)
                                 | (w_in_beq & bus.zero));
  assign bus.IRWrite    = w_run & w_in_fetch & w_rdy;
  assign bus.MemWrite   = w_run & r_memwrite;
  assign bus.RegWrite   = w_run & r_regwrite;
  assign bus.instr_done = w_done;
  assign bus.illegal    = w_run & w_in_decode & w_dec_ill;

  assign bus.IorD       = r_iord;
  assign bus.ALUSrcA    = r_alusrca;
  assign bus.ALUSrcB    = r_alusrcb;
  assign bus.ALUControl = r_aluctl;
  assign bus.sign       = r_sign;
  assign bus.PCSource   = r_pcsrc;
  assign bus.RegDst     = r_regdst;
  assign bus.MemtoReg   = r_memtoreg;
  assign bus.instr_cnt  = r_cnt;

endmodule
